// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions for the HDMI output path.
// Holds the CEA-861 720p60 constants, total-length helpers and the phase enum.
package video_timing_pkg;

    localparam int   H_ACTIVE_720P  = 1280;
    localparam int   H_FP_720P      = 110;
    localparam int   H_SYNC_720P    = 40;
    localparam int   H_BP_720P      = 220;
    localparam int   V_ACTIVE_720P  = 720;
    localparam int   V_FP_720P      = 5;
    localparam int   V_SYNC_720P    = 5;
    localparam int   V_BP_720P      = 20;
    localparam logic HSYNC_POL_720P = 1'b1;
    localparam logic VSYNC_POL_720P = 1'b1;
    localparam int   CNT_W_720P     = 12;

    // Position of a counter within one axis, in raster order.
    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_t;

    function automatic int axis_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(
        input int h_active,
        input int h_fp,
        input int h_sync,
        input int h_bp
    );
        return axis_total(h_active, h_fp, h_sync, h_bp);
    endfunction

    function automatic int v_total(
        input int v_active,
        input int v_fp,
        input int v_sync,
        input int v_bp
    );
        return axis_total(v_active, v_fp, v_sync, v_bp);
    endfunction

endpackage

// File: rtl/video_axis_timing.sv
// One raster axis: a wrapping position counter plus its phase decode.
// Ports: clk, rst (sync, high), step (advance); cnt, wrap (at last), phase.
module video_axis_timing
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE_720P,
    parameter int FP_LEN     = H_FP_720P,
    parameter int SYNC_LEN   = H_SYNC_720P,
    parameter int BP_LEN     = H_BP_720P,
    parameter int CNT_W      = CNT_W_720P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output phase_t           phase
);

    localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wrap = (cnt_q == LAST);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Boundaries are checked in raster order so zero-length phases
    // simply never match.
    always_comb begin
        phase = BACK;
        if (cnt_q < FRONT_AT) begin
            phase = ACTIVE;
        end else if (cnt_q < SYNC_AT) begin
            phase = FRONT;
        end else if (cnt_q < BACK_AT) begin
            phase = SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (default CEA-861 1280x720p60) in the pixel clock domain.
// Ports: pix_clk, rst (sync, high), en; hsync, vsync, de, x, y, line_start, frame_start.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_720P,
    parameter int   H_FP      = H_FP_720P,
    parameter int   H_SYNC    = H_SYNC_720P,
    parameter int   H_BP      = H_BP_720P,
    parameter int   V_ACTIVE  = V_ACTIVE_720P,
    parameter int   V_FP      = V_FP_720P,
    parameter int   V_SYNC    = V_SYNC_720P,
    parameter int   V_BP      = V_BP_720P,
    parameter logic HSYNC_POL = HSYNC_POL_720P,
    parameter logic VSYNC_POL = VSYNC_POL_720P,
    parameter int   CNT_W     = CNT_W_720P
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((CNT_W > 30) || (H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_cnt_w_chk
        $error("video_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             v_step;
    phase_t           h_phase;
    phase_t           v_phase;

    // The vertical axis only moves on the last pixel of an enabled line.
    assign v_step = h_wrap & en;

    video_axis_timing #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk   (pix_clk),
        .rst   (rst),
        .step  (en),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .phase (h_phase)
    );

    video_axis_timing #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk   (pix_clk),
        .rst   (rst),
        .step  (v_step),
        .cnt   (v_cnt),
        .wrap  (v_wrap_unused),
        .phase (v_phase)
    );

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Outputs describe the counter state one edge earlier; with en low
    // everything, strobes included, simply holds.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (en) begin
            hsync_d       = (h_phase == SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (v_phase == SYNC) ? VSYNC_POL : ~VSYNC_POL;
            de_d          = (h_phase == ACTIVE) && (v_phase == ACTIVE);
            x_d           = h_cnt;
            y_d           = v_cnt;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a tiny raster (8x6) and the default 720p raster.
// Vectors, a position model for the small raster, and line-level 720p checks.
module tb_video_timing_gen;

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    // Small configuration: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), pol 0.
    logic       rst_s, en_s;
    logic       hs_s, vs_s, de_s, ls_s, fs_s;
    logic [3:0] x_s, y_s;
    logic [12:0] out_s;
    assign out_s = {x_s, y_s, de_s, hs_s, vs_s, ls_s, fs_s};

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .CNT_W (4)
    ) dut_s (
        .pix_clk (pix_clk), .rst (rst_s), .en (en_s),
        .hsync (hs_s), .vsync (vs_s), .de (de_s),
        .x (x_s), .y (y_s),
        .line_start (ls_s), .frame_start (fs_s)
    );

    // Default 720p configuration.
    logic        rst_b, en_b;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [11:0] x_b, y_b;
    logic [28:0] out_b;
    assign out_b = {x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b};

    video_timing_gen dut_b (
        .pix_clk (pix_clk), .rst (rst_b), .en (en_b),
        .hsync (hs_b), .vsync (vs_b), .de (de_b),
        .x (x_b), .y (y_b),
        .line_start (ls_b), .frame_start (fs_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    function automatic logic [12:0] pk_s(input int xx, input int yy, input logic d,
                                         input logic h, input logic v, input logic l,
                                         input logic f);
        return {4'(xx), 4'(yy), d, h, v, l, f};
    endfunction

    // Expected small-raster outputs for linear position pos (pol 0).
    function automatic logic [12:0] model_s(input int pos);
        int p, h, v;
        p = pos % 48;
        h = p % 8;
        v = p / 8;
        return pk_s(h, v, (h < 4) && (v < 3), !((h == 5) || (h == 6)),
                    v != 4, h == 0, p == 0);
    endfunction

    function automatic logic [28:0] model_b(input int n);
        int h, v;
        h = n % 1650;
        v = n / 1650;
        return {12'(h), 12'(v), (h < 1280) && (v < 720),
                (h >= 1390) && (h < 1430), (v >= 725) && (v < 730),
                h == 0, (h == 0) && (v == 0)};
    endfunction

    typedef struct {
        logic        rst;
        logic        en;
        logic [12:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [12:0] exp_s;
        int          pos;
        int          frozen;
        int          fs_e[$];
        int          de_cnt, hs_cnt;
        int          ls_e[$];

        // rst, en, {x, y, de, hsync, vsync, line_start, frame_start}
        vecs.push_back('{1'b1, 1'b1, pk_s(0, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(0, 0, 1, 1, 1, 1, 1)});
        vecs.push_back('{1'b0, 1'b1, pk_s(1, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b0, pk_s(1, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(2, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(3, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(4, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(5, 0, 0, 0, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(6, 0, 0, 0, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(7, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(0, 1, 1, 1, 1, 1, 0)});
        vecs.push_back('{1'b0, 1'b0, pk_s(0, 1, 1, 1, 1, 1, 0)});
        vecs.push_back('{1'b1, 1'b0, pk_s(0, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, pk_s(0, 0, 1, 1, 1, 1, 1)});
        vecs.push_back('{1'b1, 1'b1, pk_s(0, 0, 0, 1, 1, 0, 0)});

        rst_s = 1'b1; en_s = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        tick();
        tick();

        foreach (vecs[i]) begin
            rst_s = vecs[i].rst;
            en_s  = vecs[i].en;
            tick();
            chk($sformatf("vec%0d", i), 32'(out_s), 32'(vecs[i].exp));
        end

        // Small raster from reset: two-plus frames against the position
        // model, with en low for 7 cycles while showing (3,2).
        rst_s  = 1'b0;
        pos    = 0;
        frozen = 0;
        exp_s  = pk_s(0, 0, 0, 1, 1, 0, 0);
        for (int e = 0; e < 111; e++) begin
            en_s = !((pos == 20) && (frozen < 7));
            if (!en_s) frozen++;
            tick();
            if (en_s) begin
                exp_s = model_s(pos);
                pos++;
            end
            chk($sformatf("small_e%0d", e), 32'(out_s), 32'(exp_s));
            if (en_s && fs_s) fs_e.push_back(e);
        end
        chk("small_fs_count", 32'(fs_e.size()), 32'(3));
        if (fs_e.size() >= 3) begin
            chk("small_fs_period_frozen", 32'(fs_e[1] - fs_e[0]), 32'(55));
            chk("small_fs_period_free", 32'(fs_e[2] - fs_e[1]), 32'(48));
        end
        rst_s = 1'b1;
        en_s  = 1'b0;

        // 720p: reset state, then the first line and a half.
        chk("big_reset", 32'(out_b), 32'(0));
        rst_b  = 1'b0;
        en_b   = 1'b1;
        de_cnt = 0;
        hs_cnt = 0;
        for (int n = 0; n <= 2150; n++) begin
            tick();
            chk($sformatf("big_n%0d", n), 32'(out_b), 32'(model_b(n)));
            if (n < 1650) begin
                if (de_b) de_cnt++;
                if (hs_b) hs_cnt++;
            end
            if (ls_b) ls_e.push_back(n);
        end
        chk("big_de_per_line", 32'(de_cnt), 32'(1280));
        chk("big_hs_per_line", 32'(hs_cnt), 32'(40));
        chk("big_ls_count", 32'(ls_e.size()), 32'(2));
        if (ls_e.size() >= 2) begin
            chk("big_ls_period", 32'(ls_e[1] - ls_e[0]), 32'(1650));
        end

        // Outputs now show (500,1); one cycle of reset restarts the raster.
        rst_b = 1'b1;
        tick();
        chk("big_midreset", 32'(out_b), 32'(0));
        rst_b = 1'b0;
        tick();
        chk("big_restart0", 32'(out_b), 32'(model_b(0)));
        tick();
        chk("big_restart1", 32'(out_b), 32'(model_b(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
